// File: rtl/vm_coin_acceptor.sv
// vm_coin_acceptor
//   Coin acceptor and purchase controller for a vending machine. Accumulates
//   credit from single-coin insertions, handles buy/cancel requests, and hands
//   any change to a downstream change maker through a one-cycle load strobe,
//   then waits for that change maker to report idle.
//
// Parameters
//   MAX_CREDIT : largest credit that may be accumulated, in cents
//   W          : width of every money bus, in cents
//
// Ports
//   clk              in   clock, all state changes on the rising edge
//   reset            in   asynchronous active-low reset
//   coin_dollar      in   insertion pulse, 100 cents
//   coin_half_dollar in   insertion pulse, 50 cents
//   coin_quarter     in   insertion pulse, 25 cents
//   coin_dime        in   insertion pulse, 10 cents
//   coin_nickel      in   insertion pulse, 5 cents
//   price  [W-1:0]   in   product price, sampled with buy
//   buy              in   one-cycle purchase request
//   cancel           in   one-cycle refund request
//   change_idle      in   change maker holds no remaining change
//   credit [W-1:0]   out  accumulated credit
//   change [W-1:0]   out  change presented to the change maker
//   flag_once        out  one-cycle load strobe for change
//   vend             out  one-cycle product release pulse
//   coin_reject      out  one-cycle pulse for a refused coin
//   insufficient     out  one-cycle pulse for a buy refused on low credit
//   busy             out  high while vending, loading or waiting for change
module vm_coin_acceptor #(
  parameter int MAX_CREDIT = 1000,
  parameter int W          = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         coin_dollar,
  input  logic         coin_half_dollar,
  input  logic         coin_quarter,
  input  logic         coin_dime,
  input  logic         coin_nickel,
  input  logic [W-1:0] price,
  input  logic         buy,
  input  logic         cancel,
  input  logic         change_idle,
  output logic [W-1:0] credit,
  output logic [W-1:0] change,
  output logic         flag_once,
  output logic         vend,
  output logic         coin_reject,
  output logic         insufficient,
  output logic         busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_VEND,
    ST_LOAD,
    ST_WAIT
  } state_t;

  localparam logic [W:0] MAX_W = (W+1)'(MAX_CREDIT);

  state_t       state, state_nx;
  logic [W-1:0] credit_nx, change_nx;
  logic         reject_nx, insuff_nx;

  logic [4:0]   coins;
  logic         coin_any;
  logic         coin_single;
  logic [W-1:0] coin_value;
  logic [W:0]   coin_sum;
  logic         coin_fits;

  assign coins    = {coin_dollar, coin_half_dollar, coin_quarter, coin_dime, coin_nickel};
  assign coin_any = |coins;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign coin_single = coin_any && ((coins & (coins - 5'd1)) == 5'd0);

  always_comb begin
    coin_value = '0;
    case (coins)
      5'b10000: coin_value = W'(100);
      5'b01000: coin_value = W'(50);
      5'b00100: coin_value = W'(25);
      5'b00010: coin_value = W'(10);
      5'b00001: coin_value = W'(5);
      default:  coin_value = '0;
    endcase
  end

  // One extra bit so the overflow test itself cannot wrap.
  assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};
  assign coin_fits = coin_single && (coin_sum <= MAX_W);

  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    change_nx = change;
    reject_nx = 1'b0;
    insuff_nx = 1'b0;

    case (state)
      ST_IDLE: begin
        // buy and cancel carry no meaning without credit.
        if (coin_any) begin
          if (coin_fits) begin
            credit_nx = coin_sum[W-1:0];
            state_nx  = ST_COLLECT;
          end else begin
            reject_nx = 1'b1;
          end
        end
      end

      ST_COLLECT: begin
        if (cancel) begin
          reject_nx = coin_any;
          change_nx = credit;
          credit_nx = '0;
          state_nx  = ST_LOAD;
        end else if (buy) begin
          reject_nx = coin_any;
          if (credit >= price) begin
            change_nx = credit - price;
            credit_nx = '0;
            state_nx  = ST_VEND;
          end else begin
            insuff_nx = 1'b1;
          end
        end else if (coin_any) begin
          if (coin_fits) begin
            credit_nx = coin_sum[W-1:0];
          end else begin
            reject_nx = 1'b1;
          end
        end
      end

      ST_VEND: begin
        reject_nx = coin_any;
        if (change != '0) begin
          state_nx = ST_LOAD;
        end else begin
          change_nx = '0;
          state_nx  = ST_IDLE;
        end
      end

      ST_LOAD: begin
        reject_nx = coin_any;
        state_nx  = ST_WAIT;
      end

      ST_WAIT: begin
        reject_nx = coin_any;
        if (change_idle) begin
          change_nx = '0;
          state_nx  = ST_IDLE;
        end
      end

      default: begin
        state_nx  = ST_IDLE;
        credit_nx = '0;
        change_nx = '0;
      end
    endcase
  end

  // Pulse outputs are decoded from the next state so that each one lines up
  // exactly with the cycle the machine spends in the corresponding state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      credit       <= '0;
      change       <= '0;
      flag_once    <= 1'b0;
      vend         <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      credit       <= credit_nx;
      change       <= change_nx;
      flag_once    <= (state_nx == ST_LOAD);
      vend         <= (state_nx == ST_VEND);
      coin_reject  <= reject_nx;
      insufficient <= insuff_nx;
      busy         <= (state_nx == ST_VEND) || (state_nx == ST_LOAD) || (state_nx == ST_WAIT);
    end
  end

endmodule

// File: tb/tb_vm_coin_acceptor.sv
// tb_vm_coin_acceptor
//   Directed bench for vm_coin_acceptor with hand-computed expectations.
module tb_vm_coin_acceptor;

  localparam int W = 12;

  logic         clk;
  logic         reset;
  logic         coin_dollar, coin_half_dollar, coin_quarter, coin_dime, coin_nickel;
  logic [W-1:0] price;
  logic         buy, cancel, change_idle;
  logic [W-1:0] credit, change;
  logic         flag_once, vend, coin_reject, insufficient, busy;

  int checks = 0;
  int errors = 0;

  // coin vector order: {dollar, half, quarter, dime, nickel}
  localparam logic [4:0] C_DOL = 5'b10000;
  localparam logic [4:0] C_HLF = 5'b01000;
  localparam logic [4:0] C_QTR = 5'b00100;
  localparam logic [4:0] C_DIM = 5'b00010;
  localparam logic [4:0] C_NIC = 5'b00001;
  localparam logic [4:0] C_NONE = 5'b00000;

  vm_coin_acceptor #(.MAX_CREDIT(1000), .W(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .coin_dollar      (coin_dollar),
    .coin_half_dollar (coin_half_dollar),
    .coin_quarter     (coin_quarter),
    .coin_dime        (coin_dime),
    .coin_nickel      (coin_nickel),
    .price            (price),
    .buy              (buy),
    .cancel           (cancel),
    .change_idle      (change_idle),
    .credit           (credit),
    .change           (change),
    .flag_once        (flag_once),
    .vend             (vend),
    .coin_reject      (coin_reject),
    .insufficient     (insufficient),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of stimulus, let it be sampled, then clear the pulses.
  task automatic drive(input logic [4:0] c, input logic b, input logic k);
    {coin_dollar, coin_half_dollar, coin_quarter, coin_dime, coin_nickel} = c;
    buy    = b;
    cancel = k;
    cyc();
    {coin_dollar, coin_half_dollar, coin_quarter, coin_dime, coin_nickel} = 5'b0;
    buy    = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_credit"}, int'(credit), 0);
    check({tag, "_change"}, int'(change), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_vend"}, int'(vend), 0);
    check({tag, "_flag"}, int'(flag_once), 0);
    check({tag, "_rej"}, int'(coin_reject), 0);
    check({tag, "_insuf"}, int'(insufficient), 0);
  endtask

  initial begin
    reset = 1'b0;
    {coin_dollar, coin_half_dollar, coin_quarter, coin_dime, coin_nickel} = 5'b0;
    price = '0; buy = 1'b0; cancel = 1'b0; change_idle = 1'b0;
    #12;
    all_zero("por");
    reset = 1'b1;

    // Async reset mid-stream with 60 cents of credit
    drive(C_HLF, 1'b0, 1'b0);
    drive(C_DIM, 1'b0, 1'b0);
    check("credit60", int'(credit), 60);
    #2 reset = 1'b0;
    #1 all_zero("async_rst");
    #2 reset = 1'b1;
    drive(C_NIC, 1'b0, 1'b0);
    check("post_rst_nickel", int'(credit), 5);

    // price 0 refunds the whole credit as change
    price = '0;
    drive(C_NONE, 1'b1, 1'b0);
    check("p0_vend", int'(vend), 1);
    check("p0_change", int'(change), 5);
    check("p0_credit", int'(credit), 0);
    change_idle = 1'b1;
    cyc();
    check("p0_flag", int'(flag_once), 1);
    cyc();
    check("p0_wait_busy", int'(busy), 1);
    cyc();
    check("p0_idle_busy", int'(busy), 0);
    check("p0_idle_change", int'(change), 0);
    change_idle = 1'b0;

    // Normal vend: 3 quarters + dime, price 75
    drive(C_QTR, 1'b0, 1'b0);
    drive(C_QTR, 1'b0, 1'b0);
    drive(C_QTR, 1'b0, 1'b0);
    drive(C_DIM, 1'b0, 1'b0);
    check("nv_credit85", int'(credit), 85);
    price = 12'd75;
    drive(C_NONE, 1'b1, 1'b0);
    check("nv_vend", int'(vend), 1);
    check("nv_credit0", int'(credit), 0);
    check("nv_change", int'(change), 10);
    check("nv_busy_vend", int'(busy), 1);
    check("nv_flag_vend", int'(flag_once), 0);
    cyc();
    check("nv_flag", int'(flag_once), 1);
    check("nv_vend_once", int'(vend), 0);
    cyc();
    check("nv_flag_once", int'(flag_once), 0);
    check("nv_wait_busy", int'(busy), 1);
    check("nv_wait_change", int'(change), 10);
    // coin while waiting for the change maker
    drive(C_QTR, 1'b0, 1'b0);
    check("wait_coin_rej", int'(coin_reject), 1);
    check("wait_coin_credit", int'(credit), 0);
    check("wait_still_busy", int'(busy), 1);
    change_idle = 1'b1;
    cyc();
    check("nv_idle_busy", int'(busy), 0);
    check("nv_idle_change", int'(change), 0);
    check("nv_rej_once", int'(coin_reject), 0);
    change_idle = 1'b0;

    // Exact price: no change, single busy cycle
    drive(C_DOL, 1'b0, 1'b0);
    price = 12'd100;
    drive(C_NONE, 1'b1, 1'b0);
    check("ex_vend", int'(vend), 1);
    check("ex_busy", int'(busy), 1);
    check("ex_flag", int'(flag_once), 0);
    cyc();
    check("ex_vend_off", int'(vend), 0);
    check("ex_busy_off", int'(busy), 0);
    check("ex_flag2", int'(flag_once), 0);
    check("ex_change", int'(change), 0);

    // Rejects: two coins at once, then overflow past 1000
    drive(C_DIM | C_NIC, 1'b0, 1'b0);
    check("dual_rej", int'(coin_reject), 1);
    check("dual_credit", int'(credit), 0);
    for (int unsigned i = 0; i < 9; i++) drive(C_DOL, 1'b0, 1'b0);
    drive(C_HLF, 1'b0, 1'b0);
    check("credit950", int'(credit), 950);
    check("no_rej950", int'(coin_reject), 0);
    drive(C_DOL, 1'b0, 1'b0);
    check("ovf_rej", int'(coin_reject), 1);
    check("ovf_credit", int'(credit), 950);
    drive(C_HLF, 1'b0, 1'b0);
    check("fill1000", int'(credit), 1000);
    change_idle = 1'b1;
    drive(C_NONE, 1'b0, 1'b1);
    check("c1000_change", int'(change), 1000);
    cyc();
    cyc();
    check("c1000_idle", int'(busy), 0);
    change_idle = 1'b0;

    // Low credit, then cancel with buy and a coin in the same cycle
    drive(C_QTR, 1'b0, 1'b0);
    drive(C_DIM, 1'b0, 1'b0);
    drive(C_NIC, 1'b0, 1'b0);
    price = 12'd50;
    drive(C_NONE, 1'b1, 1'b0);
    check("lo_insuf", int'(insufficient), 1);
    check("lo_credit", int'(credit), 40);
    check("lo_busy", int'(busy), 0);
    drive(C_NIC, 1'b1, 1'b1);
    check("cx_change", int'(change), 40);
    check("cx_flag", int'(flag_once), 1);
    check("cx_vend", int'(vend), 0);
    check("cx_rej", int'(coin_reject), 1);
    check("cx_credit", int'(credit), 0);
    check("cx_insuf_once", int'(insufficient), 0);
    cyc();
    check("cx_wait_vend", int'(vend), 0);
    check("cx_wait_flag", int'(flag_once), 0);
    change_idle = 1'b1;
    cyc();
    check("cx_idle_change", int'(change), 0);
    change_idle = 1'b0;

    // Reset while waiting discards pending change, no strobes afterwards
    drive(C_NIC, 1'b0, 1'b0);
    drive(C_NONE, 1'b0, 1'b1);
    cyc();
    check("rw_busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1 check("rw_change", int'(change), 0);
    #2 reset = 1'b1;
    cyc();
    all_zero("rw_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vm_coin_acceptor.md
VM_COIN_ACCEPTOR -- requirements
Module: vm_coin_acceptor

Interface
REQ-001 The block SHALL have parameter MAX_CREDIT, default 1000, giving the maximum accumulated credit in cents.
REQ-002 The block SHALL have parameter W, default 12, giving the width of all money buses in cents.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low (0 = reset asserted).
REQ-005 The block SHALL have ports coin_dollar, coin_half_dollar, coin_quarter, coin_dime and coin_nickel, each an input of 1 bit: one-cycle insertion pulses worth 100, 50, 25, 10 and 5 cents respectively.
REQ-006 The block SHALL have port price, input, W bits: product price, sampled on buy.
REQ-007 The block SHALL have port buy, input, 1 bit: one-cycle purchase request.
REQ-008 The block SHALL have port cancel, input, 1 bit: one-cycle request to refund all credit.
REQ-009 The block SHALL have port change_idle, input, 1 bit: high when the downstream change maker holds no remaining change.
REQ-010 The block SHALL have port credit, output, W bits: current accumulated credit.
REQ-011 The block SHALL have port change, output, W bits: change amount presented to the change maker.
REQ-012 The block SHALL have port flag_once, output, 1 bit: one-cycle load strobe for change.
REQ-013 The block SHALL have ports vend, coin_reject and insufficient, each an output of 1 bit: one-cycle pulses for product release, refused coin, and buy refused for low credit.
REQ-014 The block SHALL have port busy, output, 1 bit: high in the VEND, LOAD and WAIT states.

Function
REQ-015 The block SHALL register all outputs; each pulse output SHALL be high for exactly one clk cycle.
REQ-016 The state machine SHALL have states IDLE, COLLECT, VEND, LOAD and WAIT.
REQ-017 A coin SHALL be valid when exactly one coin input is high, the state is IDLE or COLLECT, and credit+value <= MAX_CREDIT.
REQ-018 A valid coin SHALL add its value to credit at the same edge; IDLE SHALL go to COLLECT.
REQ-019 An invalid coin (two or more coin inputs high, overflow, or state VEND/LOAD/WAIT) SHALL leave credit unchanged and pulse coin_reject the next cycle.
REQ-020 In COLLECT, priority SHALL be: cancel > buy > coin.
REQ-021 A coin arriving with cancel or buy SHALL be rejected.
REQ-022 buy in COLLECT with credit >= price SHALL go to VEND, latch change = credit - price, and clear credit to 0.
REQ-023 buy in COLLECT with credit < price SHALL pulse insufficient, hold credit, and stay in COLLECT.
REQ-024 buy or cancel in IDLE SHALL be ignored.
REQ-025 cancel in COLLECT SHALL latch change = credit, clear credit to 0, and go to LOAD.
REQ-026 VEND SHALL last one cycle with vend=1, then go to LOAD if change != 0, else to IDLE with change cleared to 0.
REQ-027 LOAD SHALL last one cycle with flag_once=1 and change stable, then go to WAIT.
REQ-028 WAIT SHALL hold change stable and go to IDLE, clearing change to 0, on the first cycle change_idle=1, sampled no earlier than the cycle after LOAD.
REQ-029 WAIT SHALL have no timeout.
REQ-030 buy and cancel SHALL be ignored in VEND, LOAD and WAIT.
REQ-031 Credit SHALL never exceed MAX_CREDIT, and change SHALL never wrap; price=0 SHALL be legal and refund the full credit.

Reset
REQ-032 While reset=0, the state SHALL be IDLE and credit, change, flag_once, vend, coin_reject, insufficient and busy SHALL all be 0, regardless of clk.
REQ-033 Reset asserted mid-operation, including in LOAD or WAIT, SHALL discard credit and pending change, with no flag_once or vend pulse after release.
REQ-034 The first edge after reset deasserts SHALL be able to accept a coin.

Verification
REQ-035 Reset: assert reset=0 mid-stream with credit 60 -> all outputs 0 immediately (asynchronously); after release, a nickel gives credit=5.
REQ-036 Normal vend: quarter x3, dime, price=75, buy -> credit 85 then 0; vend pulse; change=10; flag_once one cycle; busy held until change_idle=1, then IDLE and change=0.
REQ-037 Exact price: dollar, price=100, buy -> vend pulse, no flag_once, return to IDLE, busy high for 1 cycle.
REQ-038 Rejects: dime+nickel in the same cycle -> coin_reject, credit unchanged; credit 950 plus dollar -> coin_reject, credit 950; coin during WAIT -> coin_reject.
REQ-039 Low credit and cancel: credit 40, price=50, buy -> insufficient, credit 40; then cancel together with buy -> change=40, flag_once, no vend.
